genie_rr_merge: RTL and testbench

// Packet-aware round-robin arbiter that shares one valid/ready stream (and the field converter behind it)

---
 rtl/genie_arb_pkg.sv | 10 +
 rtl/genie_rr_pick.sv | 40 ++++
 rtl/genie_rr_merge.sv | 112 +++++++++++
 tb/tb_genie_rr_merge.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/genie_arb_pkg.sv
// Shared types and helpers for the round-robin packet merge.
package genie_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/genie_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module genie_rr_pick
  import genie_arb_pkg::*;
#(
  parameter  int NI = 2,
  localparam int WF = clog2_min1(NI)
) (
  input  logic [NI-1:0] req_i,
  input  logic [WF-1:0] ptr_i,
  output logic [NI-1:0] gnt_o,
  output logic [WF-1:0] idx_o
);

  localparam logic [WF:0] NI_W = (WF+1)'(NI);

  logic [NI-1:0] rot;
  logic          found;
  logic [WF-1:0] off;
  logic [WF:0]   sum;

  // Rotating the doubled vector puts the requester at ptr in bit 0.
  assign rot = NI'({req_i, req_i} >> ptr_i);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < NI; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = WF'(j);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NI_W) sum = sum - NI_W;
    idx_o = sum[WF-1:0];
    gnt_o = '0;
    if (found) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/genie_rr_merge.sv
// Packet-aware round-robin merge of NI valid/ready streams into one registered
// output stream, tagging each beat with its source index.
module genie_rr_merge
  import genie_arb_pkg::*;
#(
  parameter  int NI = 2,
  parameter  int WD = 8,
  localparam int WF = clog2_min1(NI)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WD-1:0] i_data,
  input  logic [NI-1:0]    i_eop,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WD-1:0]    o_data,
  output logic             o_eop,
  output logic [WF-1:0]    o_field,
  output logic             o_valid,
  input  logic             i_ready
);

  arb_state_t    state_q, state_d;
  logic [WF-1:0] rr_ptr_q, rr_ptr_d;
  logic [WF-1:0] lock_idx_q, lock_idx_d;
  logic          o_valid_q, o_eop_q;
  logic [WD-1:0] o_data_q;
  logic [WF-1:0] o_field_q;

  logic          load_en, acc, sel_eop;
  logic [NI-1:0] pick_gnt, gnt;
  logic [WF-1:0] pick_idx, g;
  logic [WD-1:0] sel_data;

  function automatic logic [WF-1:0] incr_mod(input logic [WF-1:0] v);
    if (int'(v) >= NI - 1) return '0;
    return v + 1'b1;
  endfunction

  genie_rr_pick #(.NI(NI)) u_pick (
    .req_i (i_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    load_en    = !o_valid_q || i_ready;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    gnt        = '0;
    if (state_q == LOCKED) begin
      g               = lock_idx_q;
      gnt[lock_idx_q] = 1'b1;
    end else begin
      g   = pick_idx;
      gnt = pick_gnt;
    end
    o_ready  = (load_en && !reset) ? gnt : '0;
    acc      = |(i_valid & o_ready);
    sel_data = i_data[WD*g +: WD];
    sel_eop  = i_eop[g];
    if (acc) begin
      if (sel_eop) begin
        state_d  = IDLE;
        rr_ptr_d = incr_mod(g);
      end else begin
        state_d    = LOCKED;
        lock_idx_d = g;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_eop_q    <= 1'b0;
      o_field_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      if (load_en) begin
        o_valid_q <= acc;
        if (acc) begin
          o_data_q  <= sel_data;
          o_eop_q   <= sel_eop;
          o_field_q <= g;
        end
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_eop   = o_eop_q;
  assign o_field = o_field_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(o_ready));

  for (genvar i = 0; i < NI; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (reset)
      (i_valid[i] && !o_ready[i]) |=>
        (!i_valid[i] || ($stable(i_data[WD*i +: WD]) && $stable(i_eop[i]))));
  end

endmodule

// File: tb/tb_genie_rr_merge.sv
// Randomized and directed bench for genie_rr_merge with a scoreboard and a
// packet-level round-robin reference model.
module tb_genie_rr_merge;

  localparam int NI = 4;
  localparam int WD = 8;
  localparam int WF = 2;

  typedef struct packed {
    logic [WD-1:0] d;
    logic          e;
    logic [WF-1:0] f;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NI*WD-1:0] i_data = '0;
  logic [NI-1:0]    i_eop = '0;
  logic [NI-1:0]    i_valid = '0;
  logic [NI-1:0]    o_ready;
  logic [WD-1:0]    o_data;
  logic             o_eop;
  logic [WF-1:0]    o_field;
  logic             o_valid;
  logic             i_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  beat_t         sb[$];
  int            m_ptr = 0;
  bit            m_locked = 0;
  int            m_lock = 0;
  bit            m_full = 0;
  bit [NI-1:0]   pend = '0;

  genie_rr_merge #(.NI(NI), .WD(WD)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_eop   (i_eop),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_eop   (o_eop),
    .o_field (o_field),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; inputs still waiting from an earlier cycle keep their beat.
  task automatic step(input logic [NI-1:0] vmask, input logic [NI-1:0] emask,
                      input logic rdy, input string tag);
    int          g;
    bit          load_en, acc;
    logic [NI-1:0] exp_ready;
    beat_t       b;
    @(posedge clk);
    #1;
    chk({tag, ":o_valid"}, 32'(o_valid), 32'(m_full));
    for (int i = 0; i < NI; i++) begin
      if (!pend[i]) begin
        i_valid[i]          = vmask[i];
        i_eop[i]            = emask[i];
        i_data[WD*i +: WD]  = WD'($urandom);
      end
    end
    i_ready = rdy;
    load_en = !m_full || rdy;
    g = -1;
    if (m_locked) g = m_lock;
    else begin
      for (int k = 0; k < NI; k++) begin
        if (g < 0 && i_valid[(m_ptr + k) % NI]) g = (m_ptr + k) % NI;
      end
    end
    exp_ready = '0;
    if (load_en && g >= 0) exp_ready[g] = 1'b1;
    acc = load_en && g >= 0 && i_valid[g];
    #1;
    chk({tag, ":o_ready"}, 32'(o_ready), 32'(exp_ready));
    if (acc) begin
      b.d = i_data[WD*g +: WD];
      b.e = i_eop[g];
      b.f = WF'(g);
      sb.push_back(b);
      if (i_eop[g]) begin
        m_ptr    = (g + 1) % NI;
        m_locked = 0;
      end else begin
        m_locked = 1;
        m_lock   = g;
      end
    end
    for (int i = 0; i < NI; i++) pend[i] = i_valid[i] && !(acc && g == i);
    if (acc) m_full = 1;
    else if (load_en) m_full = 0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    i_valid = '1;
    i_eop   = '1;
    i_ready = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      chk("rst:o_valid", 32'(o_valid), 32'd0);
      chk("rst:o_ready", 32'(o_ready), 32'd0);
      chk("rst:o_field", 32'(o_field), 32'd0);
      chk("rst:o_data", 32'(o_data), 32'd0);
    end
    reset    = 1'b0;
    i_valid  = '0;
    pend     = '0;
    m_ptr    = 0;
    m_locked = 0;
    m_full   = 0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got beat field=%0d expected no beat", o_field);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("mon_data", 32'(o_data), 32'(e.d));
        chk("mon_eop", 32'(o_eop), 32'(e.e));
        chk("mon_field", 32'(o_field), 32'(e.f));
      end
    end
  end

  initial begin
    logic [NI-1:0] vm, em;
    // Reset with every input requesting; first grant must be input 0.
    do_reset(3);
    step(4'b1111, 4'b1111, 1'b1, "t1");
    // Single-beat packets from everyone rotate 1,2,3,0,...
    for (int c = 0; c < 8; c++) step(4'b1111, 4'b1111, 1'b1, "t2");
    // Input 1 three-beat packet while 0 and 2 wait; next grant goes to 2.
    step(4'b0111, 4'b0101, 1'b1, "t3");
    step(4'b0111, 4'b0101, 1'b1, "t3");
    step(4'b0111, 4'b0111, 1'b1, "t3");
    step(4'b0101, 4'b0101, 1'b1, "t3");
    // Backpressure with a beat held in the output register.
    for (int c = 0; c < 5; c++) step(4'b1111, 4'b1111, 1'b0, "t4");
    for (int c = 0; c < 3; c++) step(4'b1111, 4'b1111, 1'b1, "t4");
    // Wrap from input 3 back to input 0.
    do_reset(1);
    step(4'b1000, 4'b0000, 1'b1, "t5");
    step(4'b1001, 4'b1001, 1'b1, "t5");
    step(4'b0001, 4'b0001, 1'b1, "t5");
    step(4'b0010, 4'b0010, 1'b1, "t5");
    // Reset while locked mid-packet on input 2.
    step(4'b0100, 4'b0000, 1'b1, "t6");
    step(4'b0100, 4'b0000, 1'b1, "t6");
    do_reset(1);
    step(4'b1111, 4'b1111, 1'b1, "t6");
    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      vm = NI'($urandom);
      for (int i = 0; i < NI; i++) em[i] = ($urandom_range(0, 2) != 0);
      step(vm, em, ($urandom_range(0, 3) != 0), "rnd");
    end
    for (int c = 0; c < 12; c++) step(4'b0000, 4'b0000, 1'b1, "drain");
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
